// File: rtl/mult_sequencer.sv
// Operand-pair FIFO feeding a handshake-driven external multiplier, with a held result register.
// Optional WAIT timeout enabled by defining MULT_SEQ_TIMEOUT_EN.
module mult_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             start,
  output logic [N-1:0]     Min,
  output logic [N-1:0]     Qin,
  input  logic             ready,
  input  logic [2*N-1:0]   AQ,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_out,
  output logic             res_err
);

  localparam int unsigned PW    = 2 * N;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_CYC = 4 * N;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC);
`endif

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;

  pair_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;

  logic             start_q, start_d;
  logic [N-1:0]     min_q, min_d;
  logic [N-1:0]     qin_q, qin_d;
  logic             seen_low_q, seen_low_d;
  logic             res_valid_q, res_valid_d;
  logic [PW-1:0]    res_out_q, res_out_d;
`ifdef MULT_SEQ_TIMEOUT_EN
  logic             res_err_q, res_err_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit_c;
`endif

  logic             push_c;
  logic             pop_c;
  logic             nempty_c;
  logic             rise_c;
  pair_t            head_c;

  assign nempty_c = (count_q != '0);
  assign push_c   = in_valid && in_ready_q;
  assign pop_c    = (state_q == S_IDLE) && nempty_c;
  assign head_c   = mem_q[rd_ptr_q];
  // A done edge counts only after ready was seen low inside WAIT.
  assign rise_c   = (state_q == S_WAIT) && ready && seen_low_q;
`ifdef MULT_SEQ_TIMEOUT_EN
  assign tmo_hit_c = (state_q == S_WAIT) && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
`endif

  // FIFO pointer / occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    in_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q] <= {a_in, b_in};
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Sequencer state register
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (nempty_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (rise_c) state_d = S_HOLD;
`ifdef MULT_SEQ_TIMEOUT_EN
        if (tmo_hit_c) state_d = S_HOLD;
`endif
      end
      S_HOLD:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs and datapath next values
  always_comb begin
    start_d     = (state_d == S_ISSUE);
    min_d       = min_q;
    qin_d       = qin_q;
    seen_low_d  = seen_low_q;
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
`ifdef MULT_SEQ_TIMEOUT_EN
    res_err_d   = res_err_q;
    tmo_cnt_d   = tmo_cnt_q;
`endif

    if (pop_c) begin
      min_d = head_c.a;
      qin_d = head_c.b;
    end

    case (state_q)
      S_ISSUE: begin
        seen_low_d = 1'b0;
`ifdef MULT_SEQ_TIMEOUT_EN
        tmo_cnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (!ready) seen_low_d = 1'b1;
`ifdef MULT_SEQ_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_hit_c) begin
          res_out_d   = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
        end
`endif
        // A genuine completion on the last timeout cycle still wins.
        if (rise_c) begin
          res_out_d   = AQ;
          res_valid_d = 1'b1;
`ifdef MULT_SEQ_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
      end
      S_HOLD: if (res_ready) res_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      start_q     <= 1'b0;
      min_q       <= '0;
      qin_q       <= '0;
      seen_low_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
`ifdef MULT_SEQ_TIMEOUT_EN
      res_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      start_q     <= start_d;
      min_q       <= min_d;
      qin_q       <= qin_d;
      seen_low_q  <= seen_low_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
`ifdef MULT_SEQ_TIMEOUT_EN
      res_err_q   <= res_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign start     = start_q;
  assign Min       = min_q;
  assign Qin       = qin_q;
  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
`ifdef MULT_SEQ_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural multiplier (ready rises 9 cycles after start).
// Covers both MULT_SEQ_TIMEOUT_EN builds.
module tb_mult_sequencer;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2 * N;
  localparam int          LAT   = 9;

  logic          clock = 1'b0;
  logic          n_rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_in, b_in;
  logic          start;
  logic [N-1:0]  Min, Qin;
  logic          ready = 1'b0;
  logic [PW-1:0] AQ = '0;
  logic          res_valid;
  logic          res_ready;
  logic [PW-1:0] res_out;
  logic          res_err;

  int tests = 0;
  int fails = 0;

  mult_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .start(start), .Min(Min), .Qin(Qin), .ready(ready), .AQ(AQ),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_err(res_err)
  );

  always #5 clock = ~clock;

  // Multiplier model; hold_low freezes its countdown so ready stays low.
  logic          hold_low = 1'b0;
  logic          busy = 1'b0;
  int            mcnt = 0;
  logic [PW-1:0] prod = '0;

  always @(negedge clock) begin
    if (start) begin
      busy  <= 1'b1;
      mcnt  <= 0;
      ready <= 1'b0;
      prod  <= PW'(Min) * PW'(Qin);
    end else if (busy && !hold_low) begin
      if (mcnt == LAT - 1) begin
        ready <= 1'b1;
        AQ    <= prod;
        busy  <= 1'b0;
      end
      mcnt <= mcnt + 1;
    end
  end

  // Cycle counter, start-pulse counter and accepted-result log.
  int            cyc = 0;
  int            start_cnt = 0;
  logic [PW-1:0] got_q[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (start) start_cnt <= start_cnt + 1;
    if (res_valid && res_ready) got_q.push_back(res_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    int w = 0;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("push_accept", 64'(w < 100), 64'(1));
    @(negedge clock);
  endtask

  task automatic wait_start(input string tag);
    int w = 0;
    while (start !== 1'b1 && w < 100) begin
      @(negedge clock);
      w++;
    end
    check(tag, 64'(w < 100), 64'(1));
  endtask

  task automatic wait_results(input int n, input string tag);
    int w = 0;
    while (got_q.size() < n && w < 400) begin
      @(negedge clock);
      w++;
    end
    check(tag, 64'(got_q.size()), 64'(n));
  endtask

  initial begin
    int t0, t1, s0, nres, w;
    logic held_ok;

    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    res_ready = 1'b0;
    n_rst     = 1'b1;
    #2 n_rst  = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_start",     64'(start),     64'(0));
    check("rst_min",       64'(Min),       64'(0));
    check("rst_qin",       64'(Qin),       64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_out",   64'(res_out),   64'(0));
    check("rst_res_err",   64'(res_err),   64'(0));
    repeat (2) @(negedge clock);
    n_rst = 1'b1;
    @(negedge clock);

    // Single op 3*5 with the result held for 10 cycles.
    s0 = start_cnt;
    push(8'd3, 8'd5);
    in_valid = 1'b0;
    wait_start("op1_start");
    t0 = cyc;
    held_ok = 1'b1;
    w = 0;
    while (res_valid !== 1'b1 && w < 100) begin
      if (Min !== 8'd3 || Qin !== 8'd5) held_ok = 1'b0;
      @(negedge clock);
      w++;
    end
    t1 = cyc;
    check("op1_latency",   64'(t1 - t0),           64'(10));
    check("op1_operands",  64'(held_ok),           64'(1));
    check("op1_res_out",   64'(res_out),           64'(15));
    check("op1_res_err",   64'(res_err),           64'(0));
    check("op1_one_start", 64'(start_cnt - s0),    64'(1));
    held_ok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (res_out !== 16'd15 || res_valid !== 1'b1) held_ok = 1'b0;
    end
    check("hold_stable", 64'(held_ok), 64'(1));

    // Backpressure: FSM stuck in HOLD, so nothing pops.
    push(8'd1,   8'd2);
    push(8'd3,   8'd4);
    push(8'd10,  8'd10);
    push(8'd200, 8'd3);
    check("bp_full", 64'(in_ready), 64'(0));
    a_in = 8'd7;
    b_in = 8'd9;
    repeat (3) @(negedge clock);
    check("bp_still_full", 64'(in_ready),        64'(0));
    check("hold_no_start", 64'(start_cnt - s0),  64'(1));
    res_ready = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("bp_release_cycles", 64'(w), 64'(2));
    @(negedge clock);
    in_valid = 1'b0;
    wait_results(6, "bp_results");
    check("res0", 64'(got_q[0]), 64'(15));
    check("res1", 64'(got_q[1]), 64'(2));
    check("res2", 64'(got_q[2]), 64'(12));
    check("res3", 64'(got_q[3]), 64'(100));
    check("res4", 64'(got_q[4]), 64'(600));
    check("res5", 64'(got_q[5]), 64'(63));

    // Ordering with res_ready held high.
    push(8'd255, 8'd255);
    push(8'd0,   8'd7);
    push(8'd16,  8'd16);
    in_valid = 1'b0;
    wait_results(9, "ord_results");
    check("ord0", 64'(got_q[6]), 64'(65025));
    check("ord1", 64'(got_q[7]), 64'(0));
    check("ord2", 64'(got_q[8]), 64'(256));
    repeat (3) @(negedge clock);

    // Stalled multiplier: timeout (if built in), then async reset mid-WAIT.
    hold_low = 1'b1;
    s0 = start_cnt;
    push(8'd9, 8'd9);
    push(8'd2, 8'd2);
    in_valid = 1'b0;
    wait_start("stall_start");
    t0 = cyc;
`ifdef MULT_SEQ_TIMEOUT_EN
    w = 0;
    while (res_valid !== 1'b1 && w < 100) begin
      @(negedge clock);
      w++;
    end
    t1 = cyc;
    // WAIT is entered one cycle after start is seen, so 32 WAIT cycles show as 33 here.
    check("tmo_latency", 64'(t1 - t0), 64'(33));
    check("tmo_res_out", 64'(res_out), 64'(0));
    check("tmo_res_err", 64'(res_err), 64'(1));
    @(negedge clock);
    wait_start("tmo_next_start");
    repeat (5) @(negedge clock);
`else
    repeat (100) @(negedge clock);
    check("stall_no_result", 64'(res_valid),        64'(0));
    check("stall_one_start", 64'(start_cnt - s0),   64'(1));
    check("stall_min",       64'(Min),              64'(9));
`endif
    #2 n_rst = 1'b0;
    #1;
    check("arst_in_ready",  64'(in_ready),  64'(1));
    check("arst_start",     64'(start),     64'(0));
    check("arst_min",       64'(Min),       64'(0));
    check("arst_qin",       64'(Qin),       64'(0));
    check("arst_res_valid", 64'(res_valid), 64'(0));
    check("arst_res_out",   64'(res_out),   64'(0));
    check("arst_res_err",   64'(res_err),   64'(0));
    @(negedge clock);
    @(negedge clock);
    hold_low = 1'b0;
    n_rst = 1'b1;
    nres = got_q.size();
    s0 = start_cnt;
    repeat (8) @(negedge clock);
    check("post_rst_no_start",  64'(start_cnt - s0), 64'(0));
    check("post_rst_no_result", 64'(got_q.size()),   64'(nres));
    push(8'd6, 8'd7);
    in_valid = 1'b0;
    wait_results(nres + 1, "post_rst_result");
    check("post_rst_product", 64'(got_q[nres]), 64'(42));
    repeat (20) @(negedge clock);
    check("post_rst_single", 64'(got_q.size()),   64'(nres + 1));
    check("post_rst_starts", 64'(start_cnt - s0), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter N, default 8: operand width; product width is 2*N.
REQ-002 SHALL have parameter DEPTH, default 4: operand-pair FIFO depth; power of two, 2..16.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port n_rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream operand pair valid.
REQ-006 SHALL have port in_ready, output, 1: FIFO can accept a pair.
REQ-007 SHALL have ports a_in and b_in, input, N each: multiplicand and multiplier.
REQ-008 SHALL have port start, output, 1: launches the downstream multiplier.
REQ-009 SHALL have ports Min and Qin, output, N each: operands presented to the multiplier.
REQ-010 SHALL have port ready, input, 1: multiplier done level.
REQ-011 SHALL have port AQ, input, 2*N: multiplier product.
REQ-012 SHALL have port res_valid, output, 1: result register holds an unconsumed product.
REQ-013 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port res_out, output, 2*N: captured product.
REQ-015 SHALL have port res_err, output, 1: captured result was aborted by timeout.

Function
REQ-016 SHALL push {a_in,b_in} into the FIFO on a clock edge where in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH); a push while full is impossible; no write/read bypass when empty.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-019 In IDLE with FIFO non-empty, SHALL pop the head into Min/Qin and go to ISSUE on the same edge.
REQ-020 In ISSUE, SHALL assert start for exactly one cycle, then go to WAIT.
REQ-021 SHALL hold Min and Qin stable from ISSUE until leaving WAIT.
REQ-022 In WAIT, SHALL detect a rising edge of ready: ready sampled low on at least one edge after ISSUE, then sampled high.
REQ-023 On that rising edge, SHALL capture AQ into res_out, clear res_err, set res_valid and go to HOLD; latency from start to res_valid is multiplier latency + 1 cycle.
REQ-024 In HOLD, SHALL keep res_out and res_valid stable until res_ready is high on an edge, then clear res_valid and go to IDLE.
REQ-025 A push and a pop on the same edge SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 SHALL issue pairs strictly in FIFO order, one multiplication in flight at a time.
REQ-027 SHALL keep start low in every state other than ISSUE.

Reset
REQ-028 On n_rst low, SHALL immediately clear the FIFO (count 0, pointers 0) and set state IDLE.
REQ-029 On n_rst low, SHALL clear start, Min, Qin, res_valid, res_out, res_err and the timeout counter to 0; in_ready SHALL read 1.
REQ-030 Reset mid-operation SHALL discard the in-flight pair and any unconsumed result without producing a result.

Configuration
REQ-031 With macro MULT_SEQ_TIMEOUT_EN defined, SHALL count cycles in WAIT.
REQ-032 With MULT_SEQ_TIMEOUT_EN defined, if no ready rising edge occurs within 4*N cycles of entering WAIT, SHALL set res_out = 0, res_err = 1, res_valid = 1 and go to HOLD.
REQ-033 Without MULT_SEQ_TIMEOUT_EN, SHALL wait in WAIT indefinitely, and res_err SHALL be tied 0.

Verification
REQ-034 Single op: push a=3, b=5; multiplier model raises ready 9 cycles after start -> one start pulse; Min=3, Qin=5 held; res_out=15 and res_valid one cycle after the ready rise.
REQ-035 Backpressure: push 5 pairs back-to-back with DEPTH=4 and no pop -> in_ready low after the 4th push; the 5th pair is accepted only after the first pop.
REQ-036 Ordering: pairs (255,255), (0,7), (16,16) with res_ready always 1 -> results 65025, 0, 256 in that order.
REQ-037 Result hold: res_ready held low 10 cycles -> res_out stable, no new start until res_ready is accepted.
REQ-038 Async reset: assert n_rst mid-WAIT -> all outputs 0 without waiting for a clock edge, in_ready=1; a new push after reset yields its correct product.
REQ-039 Timeout (macro on, N=8): ready held low -> res_valid with res_out=0, res_err=1 exactly 32 cycles after entering WAIT; macro off -> still in WAIT after 100 cycles.
